// File: rtl/data_mem_ctrl.sv
// Data-memory port controller: arbitrates a CPU port (A) and a refill port (B)
// onto a single-ported line memory, including a two-cycle read-then-write swap.
`timescale 1ns/1ps
module data_mem_ctrl #(
  parameter int CHANNELS       = 4,
  parameter int AINDEX_WIDTH   = 8,
  parameter int CH_NUM_WIDTH   = 2,
  parameter int CASH_STR_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      not_reset,
  input  logic                      a_req,
  input  logic                      a_wr,
  input  logic [AINDEX_WIDTH-1:0]   a_index,
  input  logic [CH_NUM_WIDTH-1:0]   a_chan,
  input  logic [CASH_STR_WIDTH-1:0] a_wdata,
  output logic                      a_gnt,
  output logic                      a_rvalid,
  output logic [CASH_STR_WIDTH-1:0] a_rdata,
  input  logic                      b_req,
  input  logic                      b_swap,
  input  logic [AINDEX_WIDTH-1:0]   b_index,
  input  logic [CH_NUM_WIDTH-1:0]   b_chan,
  input  logic [CASH_STR_WIDTH-1:0] b_wdata,
  output logic                      b_gnt,
  output logic                      b_rvalid,
  output logic                      b_done,
  output logic [CASH_STR_WIDTH-1:0] b_rdata,
  output logic [AINDEX_WIDTH-1:0]   mem_index,
  output logic [CH_NUM_WIDTH-1:0]   mem_chan,
  output logic                      mem_wr,
  output logic [CASH_STR_WIDTH-1:0] mem_wdata,
  input  logic [CASH_STR_WIDTH-1:0] mem_rdata,
  output logic                      busy
);

  if (CHANNELS > (1 << CH_NUM_WIDTH)) begin : g_chan_check
    $error("CH_NUM_WIDTH cannot address every way of CHANNELS");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    SWAP_WR = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic                      last_b_q, last_b_d;
  logic                      a_rvalid_q, a_rvalid_d;
  logic                      b_done_q, b_done_d;
  logic [CASH_STR_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [CASH_STR_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic [AINDEX_WIDTH-1:0]   sw_index_q, sw_index_d;
  logic [CH_NUM_WIDTH-1:0]   sw_chan_q, sw_chan_d;
  logic [CASH_STR_WIDTH-1:0] sw_wdata_q, sw_wdata_d;

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    a_rvalid_d = 1'b0;
    b_done_d   = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    sw_index_d = sw_index_q;
    sw_chan_d  = sw_chan_q;
    sw_wdata_d = sw_wdata_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    b_rvalid   = 1'b0;
    mem_wr     = 1'b0;
    mem_index  = a_index;
    mem_chan   = a_chan;
    mem_wdata  = a_wdata;

    case (state_q)
      IDLE: begin
        // Gating with not_reset keeps grants and writes quiet while reset is held.
        if (not_reset) begin
          if (a_req && (!b_req || last_b_q)) begin
            a_gnt    = 1'b1;
            mem_wr   = a_wr;
            last_b_d = 1'b0;
            if (!a_wr) begin
              a_rvalid_d = 1'b1;
              a_rdata_d  = mem_rdata;
            end
          end else if (b_req) begin
            b_gnt     = 1'b1;
            last_b_d  = 1'b1;
            mem_index = b_index;
            mem_chan  = b_chan;
            mem_wdata = b_wdata;
            if (b_swap) begin
              b_rdata_d  = mem_rdata;
              sw_index_d = b_index;
              sw_chan_d  = b_chan;
              sw_wdata_d = b_wdata;
              state_d    = SWAP_WR;
            end else begin
              mem_wr   = 1'b1;
              b_done_d = 1'b1;
            end
          end
        end
      end
      SWAP_WR: begin
        mem_index = sw_index_q;
        mem_chan  = sw_chan_q;
        mem_wdata = sw_wdata_q;
        mem_wr    = 1'b1;
        b_rvalid  = 1'b1;
        b_done_d  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- control and read-data registers ----
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_done_q   <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_rvalid_d;
      b_done_q   <= b_done_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // ---- swap write-back address/data, only meaningful in SWAP_WR ----
  always_ff @(posedge clk) begin
    sw_index_q <= sw_index_d;
    sw_chan_q  <= sw_chan_d;
    sw_wdata_q <= sw_wdata_d;
  end

  assign a_rvalid = a_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_done   = b_done_q;
  assign b_rdata  = b_rdata_q;
  assign busy     = (state_q == SWAP_WR);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: reset check, randomized run against a transaction-level
// model, then a table of directed cycle vectors for the multi-cycle corner cases.
`timescale 1ns/1ps
module tb_data_mem_ctrl;
  localparam int AW = 8;
  localparam int CW = 2;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic not_reset = 1'b0;
  logic a_req = 1'b0, a_wr = 1'b0;
  logic [AW-1:0] a_index = '0;
  logic [CW-1:0] a_chan = '0;
  logic [DW-1:0] a_wdata = '0;
  logic b_req = 1'b0, b_swap = 1'b0;
  logic [AW-1:0] b_index = '0;
  logic [CW-1:0] b_chan = '0;
  logic [DW-1:0] b_wdata = '0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, b_done, mem_wr, busy;
  logic [DW-1:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_index;
  logic [CW-1:0] mem_chan;

  data_mem_ctrl #(.CHANNELS(4), .AINDEX_WIDTH(AW), .CH_NUM_WIDTH(CW), .CASH_STR_WIDTH(DW)) dut (
    .clk(clk), .not_reset(not_reset),
    .a_req(a_req), .a_wr(a_wr), .a_index(a_index), .a_chan(a_chan), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_swap(b_swap), .b_index(b_index), .b_chan(b_chan), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_done(b_done), .b_rdata(b_rdata),
    .mem_index(mem_index), .mem_chan(mem_chan), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Line memory seen by the DUT: combinational read, write on the rising edge.
  logic [DW-1:0] tb_mem [0:(1<<(AW+CW))-1] = '{default: '0};
  assign mem_rdata = tb_mem[{mem_index, mem_chan}];
  always @(posedge clk) if (mem_wr) tb_mem[{mem_index, mem_chan}] <= mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [DW-1:0] ref_mem [0:(1<<(AW+CW))-1] = '{default: '0};
  bit            m_swap = 1'b0, m_prefer_a = 1'b1, m_a_rv = 1'b0, m_done = 1'b0;
  logic [DW-1:0] m_a_rd = '0, m_b_rd = '0, m_swd = '0;
  logic [AW-1:0] m_sidx = '0;
  logic [CW-1:0] m_sch = '0;
  logic          e_ag, e_bg, e_wr, e_a_rv, e_b_rv, e_done, e_busy;
  logic [AW-1:0] e_idx;
  logic [CW-1:0] e_ch;
  logic [DW-1:0] e_wd, e_a_rd, e_b_rd;

  task automatic model_step();
    e_ag = 1'b0; e_bg = 1'b0; e_wr = 1'b0;
    e_idx = a_index; e_ch = a_chan; e_wd = a_wdata;
    if (!not_reset) begin
      m_swap = 1'b0; m_prefer_a = 1'b1; m_a_rv = 1'b0; m_done = 1'b0;
      m_a_rd = '0; m_b_rd = '0;
      e_a_rv = 1'b0; e_b_rv = 1'b0; e_done = 1'b0; e_busy = 1'b0;
      e_a_rd = '0; e_b_rd = '0;
      return;
    end
    e_a_rv = m_a_rv; e_a_rd = m_a_rd; e_b_rd = m_b_rd;
    e_done = m_done; e_busy = m_swap; e_b_rv = m_swap;
    m_a_rv = 1'b0; m_done = 1'b0;
    if (m_swap) begin
      e_wr = 1'b1; e_idx = m_sidx; e_ch = m_sch; e_wd = m_swd;
      ref_mem[{m_sidx, m_sch}] = m_swd;
      m_done = 1'b1; m_swap = 1'b0;
    end else if (a_req && (!b_req || m_prefer_a)) begin
      e_ag = 1'b1; e_wr = a_wr; m_prefer_a = 1'b0;
      if (a_wr) ref_mem[{a_index, a_chan}] = a_wdata;
      else begin m_a_rv = 1'b1; m_a_rd = ref_mem[{a_index, a_chan}]; end
    end else if (b_req) begin
      e_bg = 1'b1; m_prefer_a = 1'b1;
      e_idx = b_index; e_ch = b_chan; e_wd = b_wdata;
      if (b_swap) begin
        m_b_rd = ref_mem[{b_index, b_chan}];
        m_swap = 1'b1; m_sidx = b_index; m_sch = b_chan; m_swd = b_wdata;
      end else begin
        e_wr = 1'b1; ref_mem[{b_index, b_chan}] = b_wdata; m_done = 1'b1;
      end
    end
  endtask

  task automatic check_model(input int cyc);
    string p;
    p = $sformatf("rnd%0d.", cyc);
    chk({p, "a_gnt"},     DW'(a_gnt),     DW'(e_ag));
    chk({p, "b_gnt"},     DW'(b_gnt),     DW'(e_bg));
    chk({p, "mem_wr"},    DW'(mem_wr),    DW'(e_wr));
    chk({p, "mem_index"}, DW'(mem_index), DW'(e_idx));
    chk({p, "mem_chan"},  DW'(mem_chan),  DW'(e_ch));
    chk({p, "mem_wdata"}, mem_wdata,      e_wd);
    chk({p, "a_rvalid"},  DW'(a_rvalid),  DW'(e_a_rv));
    chk({p, "a_rdata"},   a_rdata,        e_a_rd);
    chk({p, "b_rvalid"},  DW'(b_rvalid),  DW'(e_b_rv));
    chk({p, "b_rdata"},   b_rdata,        e_b_rd);
    chk({p, "b_done"},    DW'(b_done),    DW'(e_done));
    chk({p, "busy"},      DW'(busy),      DW'(e_busy));
  endtask

  function automatic logic [AW-1:0] pick_idx();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h05;
      default: return 8'hFF;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]    ctl;   // {not_reset, a_req, a_wr, b_req, b_swap}
    logic [AW-1:0] ai;
    logic [CW-1:0] ac;
    logic [DW-1:0] awd;
    logic [AW-1:0] bi;
    logic [CW-1:0] bc;
    logic [DW-1:0] bwd;
    logic [6:0]    flg;   // {a_gnt, b_gnt, mem_wr, a_rvalid, b_rvalid, b_done, busy}
    logic [AW-1:0] ei;
    logic [CW-1:0] ec;
    logic [DW-1:0] ewd;
    logic [1:0]    rsel;  // 1: a_rdata checked, 2: b_rdata checked
    logic [DW-1:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] ctl, input logic [AW-1:0] ai, input logic [CW-1:0] ac,
                              input logic [DW-1:0] awd, input logic [AW-1:0] bi, input logic [CW-1:0] bc,
                              input logic [DW-1:0] bwd, input logic [6:0] flg, input logic [AW-1:0] ei,
                              input logic [CW-1:0] ec, input logic [DW-1:0] ewd, input logic [1:0] rsel,
                              input logic [DW-1:0] erd);
    vec_t v;
    v.ctl = ctl; v.ai = ai; v.ac = ac; v.awd = awd; v.bi = bi; v.bc = bc; v.bwd = bwd;
    v.flg = flg; v.ei = ei; v.ec = ec; v.ewd = ewd; v.rsel = rsel; v.erd = erd;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    bit a_hold, b_hold;
    string p;
    vecs.push_back(mk(5'b00000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0000000, 8'h00, 2'd0, 64'h0,    2'd1, 64'h0));
    // CPU write then read of 0x12/way2
    vecs.push_back(mk(5'b11100, 8'h12, 2'd2, 64'hDEAD, 8'h00, 2'd0, 64'h0,    7'b1010000, 8'h12, 2'd2, 64'hDEAD, 2'd0, 64'h0));
    vecs.push_back(mk(5'b11000, 8'h12, 2'd2, 64'h0,    8'h00, 2'd0, 64'h0,    7'b1000000, 8'h12, 2'd2, 64'h0,    2'd0, 64'h0));
    vecs.push_back(mk(5'b10000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0001000, 8'h00, 2'd0, 64'h0,    2'd1, 64'hDEAD));
    // reset, then both ports held: A, B, A, B
    vecs.push_back(mk(5'b00000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0000000, 8'h00, 2'd0, 64'h0,    2'd1, 64'h0));
    vecs.push_back(mk(5'b11110, 8'h30, 2'd0, 64'hA0,   8'h31, 2'd1, 64'hB0,   7'b1010000, 8'h30, 2'd0, 64'hA0,   2'd0, 64'h0));
    vecs.push_back(mk(5'b11110, 8'h30, 2'd0, 64'hA0,   8'h31, 2'd1, 64'hB0,   7'b0110000, 8'h31, 2'd1, 64'hB0,   2'd0, 64'h0));
    vecs.push_back(mk(5'b11110, 8'h30, 2'd0, 64'hA0,   8'h31, 2'd1, 64'hB0,   7'b1010010, 8'h30, 2'd0, 64'hA0,   2'd0, 64'h0));
    vecs.push_back(mk(5'b11110, 8'h30, 2'd0, 64'hA0,   8'h31, 2'd1, 64'hB0,   7'b0110000, 8'h31, 2'd1, 64'hB0,   2'd0, 64'h0));
    vecs.push_back(mk(5'b10000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0000010, 8'h00, 2'd0, 64'h0,    2'd0, 64'h0));
    // swap on 0x05/way1 with A waiting during SWAP_WR and B fields changing after grant
    vecs.push_back(mk(5'b11100, 8'h05, 2'd1, 64'h1111, 8'h00, 2'd0, 64'h0,    7'b1010000, 8'h05, 2'd1, 64'h1111, 2'd0, 64'h0));
    vecs.push_back(mk(5'b10011, 8'h00, 2'd0, 64'h0,    8'h05, 2'd1, 64'h2222, 7'b0100000, 8'h05, 2'd1, 64'h2222, 2'd0, 64'h0));
    vecs.push_back(mk(5'b11000, 8'h05, 2'd1, 64'h0,    8'h77, 2'd3, 64'h9999, 7'b0010101, 8'h05, 2'd1, 64'h2222, 2'd2, 64'h1111));
    vecs.push_back(mk(5'b11000, 8'h05, 2'd1, 64'h0,    8'h00, 2'd0, 64'h0,    7'b1000010, 8'h05, 2'd1, 64'h0,    2'd2, 64'h1111));
    vecs.push_back(mk(5'b10000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0001000, 8'h00, 2'd0, 64'h0,    2'd1, 64'h2222));
    // reset during SWAP_WR aborts the write-back
    vecs.push_back(mk(5'b10011, 8'h00, 2'd0, 64'h0,    8'h05, 2'd1, 64'h3333, 7'b0100000, 8'h05, 2'd1, 64'h3333, 2'd0, 64'h0));
    vecs.push_back(mk(5'b00000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0000000, 8'h00, 2'd0, 64'h0,    2'd2, 64'h0));
    vecs.push_back(mk(5'b10000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0000000, 8'h00, 2'd0, 64'h0,    2'd1, 64'h0));
    vecs.push_back(mk(5'b11000, 8'h05, 2'd1, 64'h0,    8'h00, 2'd0, 64'h0,    7'b1000000, 8'h05, 2'd1, 64'h0,    2'd0, 64'h0));
    vecs.push_back(mk(5'b10000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0001000, 8'h00, 2'd0, 64'h0,    2'd1, 64'h2222));
    // plain refill write at the last set/way
    vecs.push_back(mk(5'b10010, 8'h00, 2'd0, 64'h0,    8'hFF, 2'd3, 64'h4444, 7'b0110000, 8'hFF, 2'd3, 64'h4444, 2'd0, 64'h0));
    vecs.push_back(mk(5'b10000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0000010, 8'h00, 2'd0, 64'h0,    2'd0, 64'h0));
    vecs.push_back(mk(5'b11000, 8'hFF, 2'd3, 64'h0,    8'h00, 2'd0, 64'h0,    7'b1000000, 8'hFF, 2'd3, 64'h0,    2'd0, 64'h0));
    vecs.push_back(mk(5'b10000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0001000, 8'h00, 2'd0, 64'h0,    2'd1, 64'h4444));
    vecs.push_back(mk(5'b10000, 8'h00, 2'd0, 64'h0,    8'h00, 2'd0, 64'h0,    7'b0000000, 8'h00, 2'd0, 64'h0,    2'd1, 64'h4444));

    // Reset held with both ports requesting: everything stays quiet.
    a_req = 1'b1; a_wr = 1'b1; b_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.a_gnt",    DW'(a_gnt),    '0);
    chk("rst.b_gnt",    DW'(b_gnt),    '0);
    chk("rst.mem_wr",   DW'(mem_wr),   '0);
    chk("rst.a_rvalid", DW'(a_rvalid), '0);
    chk("rst.b_rvalid", DW'(b_rvalid), '0);
    chk("rst.b_done",   DW'(b_done),   '0);
    chk("rst.busy",     DW'(busy),     '0);
    chk("rst.a_rdata",  a_rdata,       '0);
    chk("rst.b_rdata",  b_rdata,       '0);

    // Randomized traffic against the reference model.
    a_hold = 1'b0; b_hold = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      not_reset = ($urandom_range(0, 39) != 0);
      if (!a_hold) begin
        a_req   = 1'($urandom_range(0, 1));
        a_wr    = 1'($urandom_range(0, 1));
        a_index = pick_idx();
        a_chan  = CW'($urandom_range(0, 3));
        a_wdata = {$urandom(), $urandom()};
      end
      if (!b_hold) begin
        b_req   = ($urandom_range(0, 2) == 0);
        b_swap  = 1'($urandom_range(0, 1));
        b_index = pick_idx();
        b_chan  = CW'($urandom_range(0, 3));
        b_wdata = {$urandom(), $urandom()};
      end
      #1;
      model_step();
      check_model(cyc);
      a_hold = a_req && !e_ag;
      b_hold = b_req && !e_bg;
    end

    // Directed cycle vectors.
    foreach (vecs[i]) begin
      @(negedge clk);
      {not_reset, a_req, a_wr, b_req, b_swap} = vecs[i].ctl;
      a_index = vecs[i].ai; a_chan = vecs[i].ac; a_wdata = vecs[i].awd;
      b_index = vecs[i].bi; b_chan = vecs[i].bc; b_wdata = vecs[i].bwd;
      #1;
      p = $sformatf("vec%0d.", i);
      chk({p, "flags"},     DW'({a_gnt, b_gnt, mem_wr, a_rvalid, b_rvalid, b_done, busy}), DW'(vecs[i].flg));
      chk({p, "mem_index"}, DW'(mem_index), DW'(vecs[i].ei));
      chk({p, "mem_chan"},  DW'(mem_chan),  DW'(vecs[i].ec));
      chk({p, "mem_wdata"}, mem_wdata,      vecs[i].ewd);
      if (vecs[i].rsel == 2'd1) chk({p, "a_rdata"}, a_rdata, vecs[i].erd);
      if (vecs[i].rsel == 2'd2) chk({p, "b_rdata"}, b_rdata, vecs[i].erd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
